// File: rtl/unstacker.sv
// unstacker: serializes 128-bit read phrases into four 32-bit pixel words.
// The least-significant word is sent first. This is the read-side
// counterpart of the 32->128 stacker. It sits between the MIG read FIFO
// and the pixel consumer.
//
// A two-slot buffer holds the chunk being emitted (cur) and one waiting
// chunk (nxt). This keeps one output word per cycle across chunk
// boundaries.
//
// Ports:
//   clk_in        : single clock, posedge
//   rst_in        : synchronous active-high reset
//   chunk_tvalid  : input chunk valid
//   chunk_tready  : unstacker can accept a chunk (registered state only)
//   chunk_tdata   : 128-bit chunk, bits [31:0] emitted first
//   chunk_tlast   : chunk ends a frame/burst
//   pixel_tvalid  : output word valid
//   pixel_tready  : downstream accepts the word
//   pixel_tdata   : 32-bit output word
//   pixel_tlast   : last word of a chunk that carried chunk_tlast
module unstacker (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         chunk_tvalid,
  output logic         chunk_tready,
  input  logic [127:0] chunk_tdata,
  input  logic         chunk_tlast,
  output logic         pixel_tvalid,
  input  logic         pixel_tready,
  output logic [31:0]  pixel_tdata,
  output logic         pixel_tlast
);

  localparam int CHUNK_W = 128;
  localparam int WORD_W  = 32;

  logic [CHUNK_W-1:0] cur_data_q, cur_data_d;
  logic               cur_tlast_q, cur_tlast_d;
  logic               cur_valid_q, cur_valid_d;
  logic [1:0]         cur_idx_q, cur_idx_d;
  logic [CHUNK_W-1:0] nxt_data_q, nxt_data_d;
  logic               nxt_tlast_q, nxt_tlast_d;
  logic               nxt_valid_q, nxt_valid_d;

  logic accept_in;
  logic accept_out;
  logic cur_done;

  // Ready depends only on the nxt slot.
  // It never looks at pixel_tready, so it adds no combinational path
  // through the block.
  assign chunk_tready = !nxt_valid_q && !rst_in;
  assign pixel_tvalid = cur_valid_q;
  assign pixel_tdata  = cur_data_q[{cur_idx_q, 5'd0} +: WORD_W];
  assign pixel_tlast  = cur_valid_q && cur_tlast_q && (cur_idx_q == 2'd3);

  assign accept_in  = chunk_tvalid && chunk_tready;
  assign accept_out = pixel_tvalid && pixel_tready;
  assign cur_done   = accept_out && (cur_idx_q == 2'd3);

  always_comb begin
    cur_data_d  = cur_data_q;
    cur_tlast_d = cur_tlast_q;
    cur_valid_d = cur_valid_q;
    cur_idx_d   = cur_idx_q;
    nxt_data_d  = nxt_data_q;
    nxt_tlast_d = nxt_tlast_q;
    nxt_valid_d = nxt_valid_q;

    if (cur_done) begin
      if (nxt_valid_q) begin
        cur_data_d  = nxt_data_q;
        cur_tlast_d = nxt_tlast_q;
        cur_valid_d = 1'b1;
        cur_idx_d   = 2'd0;
        nxt_valid_d = accept_in;
        // Unreachable while ready is gated by nxt_valid.
        // It is kept so that no chunk can ever be dropped.
        if (accept_in) begin
          nxt_data_d  = chunk_tdata;
          nxt_tlast_d = chunk_tlast;
        end
      end else if (accept_in) begin
        // Bypass nxt so there is no bubble between chunks.
        cur_data_d  = chunk_tdata;
        cur_tlast_d = chunk_tlast;
        cur_valid_d = 1'b1;
        cur_idx_d   = 2'd0;
      end else begin
        cur_valid_d = 1'b0;
        cur_idx_d   = 2'd0;
      end
    end else begin
      if (accept_out) begin
        cur_idx_d = cur_idx_q + 2'd1;
      end
      if (accept_in) begin
        if (!cur_valid_q) begin
          cur_data_d  = chunk_tdata;
          cur_tlast_d = chunk_tlast;
          cur_valid_d = 1'b1;
          cur_idx_d   = 2'd0;
        end else begin
          nxt_data_d  = chunk_tdata;
          nxt_tlast_d = chunk_tlast;
          nxt_valid_d = 1'b1;
        end
      end
    end
  end

  // Data is cleared on reset too, so pixel_tdata reads zero afterwards.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cur_data_q  <= '0;
      cur_tlast_q <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_idx_q   <= 2'd0;
      nxt_data_q  <= '0;
      nxt_tlast_q <= 1'b0;
      nxt_valid_q <= 1'b0;
    end else begin
      cur_data_q  <= cur_data_d;
      cur_tlast_q <= cur_tlast_d;
      cur_valid_q <= cur_valid_d;
      cur_idx_q   <= cur_idx_d;
      nxt_data_q  <= nxt_data_d;
      nxt_tlast_q <= nxt_tlast_d;
      nxt_valid_q <= nxt_valid_d;
    end
  end

endmodule

// File: doc/unstacker.md
# unstacker

Read-side counterpart of the 32→128 stacker: accepts 128-bit MIG read phrases on an AXI-Stream-style input and serializes each into four 32-bit pixel words, least-significant word first, on an AXI-Stream-style output. Sits between the DRAM read path (MIG read FIFO) and the pixel/video consumer. A two-slot chunk buffer sustains one output word per cycle across chunk boundaries.

## Interface

- Parameters: none. Widths are fixed at a 128-bit chunk, a 32-bit word and 4 words per chunk.
- clk_in, input, 1: the single clock; all logic is on posedge.
- rst_in, input, 1: synchronous, active-high reset.
- chunk_tvalid, input, 1: input chunk valid.
- chunk_tready, output, 1: unstacker can accept a chunk.
- chunk_tdata, input, 128: chunk; bits [31:0] are emitted first.
- chunk_tlast, input, 1: the chunk ends a frame or burst.
- pixel_tvalid, output, 1: output word valid.
- pixel_tready, input, 1: downstream accepts the word.
- pixel_tdata, output, 32: output word.
- pixel_tlast, output, 1: this is the last word of a chunk flagged by chunk_tlast.

## Operation

- State:
  - cur slot: data[127:0], tlast, valid, idx[1:0].
  - nxt slot: data[127:0], tlast, valid.
- accept_in = chunk_tvalid && chunk_tready.
- accept_out = pixel_tvalid && pixel_tready.
- cur_done = accept_out && idx == 3.
- chunk_tready = !nxt_valid && !rst_in. It is derived only from registered state, with no combinational path from pixel_tready.
- pixel_tvalid = cur_valid.
- pixel_tdata = cur_data[32*idx +: 32].
- pixel_tlast = cur_valid && cur_tlast && idx == 3.
- accept_out with idx < 3: idx increments and nothing else changes.
- cur_done:
  - If nxt_valid: cur loads nxt with idx = 0 and stays valid. nxt_valid clears unless accept_in this cycle, in which case the incoming chunk loads nxt.
  - Else if accept_in: the incoming chunk loads cur directly with idx = 0 and stays valid.
  - Else: cur_valid clears and idx is set to 0.
- accept_in with no cur_done:
  - cur_valid = 0: the chunk loads cur with idx = 0.
  - cur_valid = 1: the chunk loads nxt and nxt_valid sets.
- chunk_tlast propagates only to word 3 of its own chunk. Words 0–2 of that chunk have pixel_tlast = 0.
- Chunks are never dropped, reordered or duplicated. Each accepted chunk yields exactly 4 accepted words, in order [31:0], [63:32], [95:64], [127:96].

## Timing

- Reset, synchronous on a clk_in edge with rst_in high:
  - cur_valid, nxt_valid, cur_tlast and nxt_tlast go to 0; idx goes to 0.
  - cur_data and nxt_data go to 0.
  - Outputs after reset: pixel_tvalid = 0, pixel_tdata = 0, pixel_tlast = 0, chunk_tready = 0 while rst_in is high and 1 on the first cycle after release.
  - Reset mid-chunk discards any partially emitted chunk and any buffered chunk.
- Latency: a chunk accepted at edge N into an empty cur drives pixel_tvalid = 1 with word 0 from edge N onward. That is one cycle from chunk_tvalid sampling to the first word.
- Throughput with pixel_tready held high:
  - 1 word per cycle, 1 chunk per 4 cycles, no bubble between chunks provided the next chunk arrives at least 1 cycle before cur_done.
  - chunk_tready deasserts only while nxt is occupied.
- Backpressure:
  - With pixel_tready = 0, pixel_tdata, pixel_tlast and idx hold.
  - After at most 2 chunks are buffered, chunk_tready = 0.
- AXI rules: pixel_tvalid, once high, stays high with stable data until accept_out. chunk_tvalid is never a prerequisite for chunk_tready.
- Simultaneous cur_done and accept_in with nxt full cannot occur, because chunk_tready = 0 when nxt_valid = 1.

## Test plan

- Single chunk 0x44444444_33333333_22222222_11111111, tlast = 1, pixel_tready = 1 → words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting one cycle after acceptance. pixel_tlast = 1 only on 0x44444444.
- 8 back-to-back chunks with chunk_tvalid = 1 and pixel_tready = 1 → 32 words on 32 consecutive cycles with no gaps, in order. chunk_tready never low for more than 3 consecutive cycles.
- Backpressure: pixel_tready = 0 for 10 cycles mid-chunk (idx = 2) while chunks are offered → pixel_tdata holds word 2. Exactly 1 extra chunk is accepted, then chunk_tready = 0. After release, output resumes at word 2 with no loss.
- tlast isolation: chunks with tlast pattern 0,1,0 → pixel_tlast high only on word 7 of 12.
- Reset mid-operation: assert rst_in with cur at idx = 1 and nxt full → next cycle pixel_tvalid = 0 and chunk_tready = 0. After release, a new chunk emits from word 0 and no stale data appears.
- Random valid/ready on both sides for 10k cycles → scoreboard confirms in-order, lossless word stream and tlast placement.
